// File: rtl/rv_imem_resp_pkg.sv
// rtl/rv_imem_resp_pkg.sv - shared types, constants and helpers for the instruction-memory responder
package rv_imem_resp_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } t_imem_state;

  // addi x0, x0, 0 -- returned in place of any faulting fetch
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // A fetch faults when the PC is not word aligned or its word index lies past the array.
  // The comparison uses the full 32-bit word index so huge PCs never alias into range.
  function automatic logic pc_fault(input logic [31:0] pc, input logic [31:0] words);
    return (pc[1:0] != 2'b00) || ({2'b00, pc[31:2]} >= words);
  endfunction

endpackage

// File: rtl/rv_imem_array.sv
// rtl/rv_imem_array.sv - word-addressed instruction storage, one sync write port and one comb read port
module rv_imem_array #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data
);

  localparam int          AW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] WORDS_W = 32'(MEM_WORDS);

  logic [31:0] mem [MEM_WORDS];
  logic        wr_ok;
  logic        rd_ok;

  assign wr_ok = (wr_addr < WORDS_W);
  assign rd_ok = (rd_addr < WORDS_W);

  // Backdoor program load; out-of-range indices are silently dropped
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) begin
      mem[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  // Read returns the pre-edge contents, so a same-cycle load is not visible to a capture
  assign rd_data = rd_ok ? mem[rd_addr[AW-1:0]] : 32'h0;

endmodule

// File: rtl/rv_imem_resp.sv
// rtl/rv_imem_resp.sv - I_MEM end of the fetch interface with wait states, flush and decode stall
module rv_imem_resp
  import rv_imem_resp_pkg::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_Q100H,
  input  logic [31:0] req_pc_Q100H,
  output logic        req_ready_Q100H,
  input  logic        flush_Q102H,
  output logic        rsp_valid_Q101H,
  output logic [31:0] rsp_instr_Q101H,
  output logic [31:0] rsp_pc_Q101H,
  output logic        rsp_fault_Q101H,
  input  logic        rsp_ready_Q101H,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam logic [31:0] WORDS_W   = 32'(MEM_WORDS);
  localparam t_imem_state ACC_STATE = (WAIT_STATES == 0) ? RESP : WAIT;
  localparam logic [3:0]  ACC_CNT   = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES);
  localparam logic        ACC_VALID = (WAIT_STATES == 0);

  t_imem_state state;
  logic [3:0]  cnt;
  logic [31:0] pc_q;
  logic        accept;
  logic        wait_done;
  logic        load_rsp;
  logic [31:0] cap_pc;
  logic [31:0] rd_data;
  logic        cap_fault;
  logic [31:0] cap_instr;

  // A new PC can enter only when the response slot is empty or being drained this cycle
  assign req_ready_Q100H = !flush_Q102H &&
                           ((state == IDLE) || ((state == RESP) && rsp_ready_Q101H));
  assign accept          = req_valid_Q100H && req_ready_Q100H;
  assign wait_done       = (state == WAIT) && (cnt == 4'd1);

  // Zero-wait accesses capture straight from the request; otherwise at the end of WAIT
  assign load_rsp  = (accept && ACC_VALID) || wait_done;
  assign cap_pc    = (state == WAIT) ? pc_q : req_pc_Q100H;
  assign cap_fault = pc_fault(cap_pc, WORDS_W);
  assign cap_instr = cap_fault ? NOP_INSTR : rd_data;

  rv_imem_array #(
    .MEM_WORDS (MEM_WORDS)
  ) u_array (
    .clk     (clk),
    .wr_en   (ld_en),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_addr ({2'b00, cap_pc[31:2]}),
    .rd_data (rd_data)
  );

  // Responder FSM, wait counter, latched PC and registered response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      pc_q            <= 32'h0;
      rsp_valid_Q101H <= 1'b0;
      rsp_instr_Q101H <= NOP_INSTR;
      rsp_pc_Q101H    <= 32'h0;
      rsp_fault_Q101H <= 1'b0;
    end else if (flush_Q102H) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      rsp_valid_Q101H <= 1'b0;
    end else begin
      if (accept) begin
        pc_q <= req_pc_Q100H;
      end
      if (load_rsp) begin
        rsp_pc_Q101H    <= cap_pc;
        rsp_instr_Q101H <= cap_instr;
        rsp_fault_Q101H <= cap_fault;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state           <= ACC_STATE;
            cnt             <= ACC_CNT;
            rsp_valid_Q101H <= ACC_VALID;
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state           <= RESP;
            cnt             <= 4'd0;
            rsp_valid_Q101H <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready_Q101H) begin
            if (accept) begin
              state           <= ACC_STATE;
              cnt             <= ACC_CNT;
              rsp_valid_Q101H <= ACC_VALID;
            end else begin
              state           <= IDLE;
              rsp_valid_Q101H <= 1'b0;
            end
          end
        end
        default: begin
          state           <= IDLE;
          cnt             <= 4'd0;
          rsp_valid_Q101H <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_imem_resp.sv
// tb/tb_rv_imem_resp.sv - scoreboard bench for rv_imem_resp with zero and three wait states
module tb_rv_imem_resp;

  localparam int          MW  = 64;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
    int          rdy;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid [2];
  logic [31:0] req_pc    [2];
  logic        req_ready [2];
  logic        flush     [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_instr [2];
  logic [31:0] rsp_pc    [2];
  logic        rsp_fault [2];
  logic        rsp_ready [2];
  logic        ld_en     [2];
  logic [31:0] ld_addr   [2];
  logic [31:0] ld_data   [2];

  exp_t        sb [2][$];
  logic [31:0] mem_m [2][MW];
  logic        acc [2];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic        ev;
  logic        er;
  exp_t        e;

  rv_imem_resp #(.MEM_WORDS(MW), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid_Q100H(req_valid[0]), .req_pc_Q100H(req_pc[0]), .req_ready_Q100H(req_ready[0]),
    .flush_Q102H(flush[0]),
    .rsp_valid_Q101H(rsp_valid[0]), .rsp_instr_Q101H(rsp_instr[0]), .rsp_pc_Q101H(rsp_pc[0]),
    .rsp_fault_Q101H(rsp_fault[0]), .rsp_ready_Q101H(rsp_ready[0]),
    .ld_en(ld_en[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0])
  );

  rv_imem_resp #(.MEM_WORDS(MW), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid_Q100H(req_valid[1]), .req_pc_Q100H(req_pc[1]), .req_ready_Q100H(req_ready[1]),
    .flush_Q102H(flush[1]),
    .rsp_valid_Q101H(rsp_valid[1]), .rsp_instr_Q101H(rsp_instr[1]), .rsp_pc_Q101H(rsp_pc[1]),
    .rsp_fault_Q101H(rsp_fault[1]), .rsp_ready_Q101H(rsp_ready[1]),
    .ld_en(ld_en[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] @cyc %0d: got %h expected %h", nm, inst, cyc, act, exp);
    end
  endtask

  function automatic int ws_of(input int inst);
    return (inst == 0) ? 0 : 3;
  endfunction

  function automatic logic [31:0] rand_pc();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 6)       return 32'($urandom_range(0, MW - 1)) * 4;
    else if (r == 6) return 32'($urandom_range(0, MW - 1)) * 4 + 32'($urandom_range(1, 3));
    else if (r == 7) return 32'(MW * 4) + 32'($urandom_range(0, 3)) * 4;
    else if (r == 8) return ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC : $urandom;
    else             return 32'((MW - 1) * 4);
  endfunction

  // Monitor: expected timing from the accept cycle, outputs compared against the queued front
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        sb[i].delete();
        acc[i] = 1'b0;
      end else begin
        ev = (sb[i].size() > 0) && (cyc >= sb[i][0].rdy);
        er = !flush[i] && ((sb[i].size() == 0) || (ev && rsp_ready[i]));
        chk("req_ready", i, 32'(req_ready[i]), 32'(er));
        chk("rsp_valid", i, 32'(rsp_valid[i]), 32'(ev));
        if (ev) begin
          chk("rsp_pc", i, rsp_pc[i], sb[i][0].pc);
          chk("rsp_instr", i, rsp_instr[i], sb[i][0].instr);
          chk("rsp_fault", i, 32'(rsp_fault[i]), 32'(sb[i][0].fault));
        end
        if (flush[i]) begin
          sb[i].delete();
        end else begin
          if (ev && rsp_ready[i]) void'(sb[i].pop_front());
          if (req_valid[i] && er) begin
            e.pc    = req_pc[i];
            e.fault = (req_pc[i] % 4 != 0) || (req_pc[i] / 4 >= MW);
            e.instr = NOP;
            if (!e.fault) e.instr = mem_m[i][req_pc[i] / 4];
            e.rdy   = cyc + 1 + ws_of(i);
            sb[i].push_back(e);
          end
        end
        acc[i] = req_valid[i] && er;
        if (ld_en[i] && (ld_addr[i] < MW)) mem_m[i][ld_addr[i]] = ld_data[i];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_pc[i]    = 32'h0;
      flush[i]     = 1'b0;
      rsp_ready[i] = 1'b1;
      ld_en[i]     = 1'b0;
      ld_addr[i]   = 32'h0;
      ld_data[i]   = 32'h0;
    end
  endtask

  task automatic req(input int i, input logic [31:0] pc);
    req_valid[i] = 1'b1;
    req_pc[i]    = pc;
    step();
    req_valid[i] = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      chk("reset rsp_valid", i, 32'(rsp_valid[i]), 32'h0);
      chk("reset rsp_instr", i, rsp_instr[i], NOP);
      chk("reset rsp_pc", i, rsp_pc[i], 32'h0);
      chk("reset rsp_fault", i, 32'(rsp_fault[i]), 32'h0);
    end
    step();
    rst = 1'b0;

    // Preload both arrays, including a few ignored out-of-range writes
    for (int w = 0; w < MW + 4; w++) begin
      for (int i = 0; i < 2; i++) begin
        ld_en[i]   = 1'b1;
        ld_addr[i] = 32'(w);
        ld_data[i] = (w == 0) ? 32'h00500093 : $urandom;
      end
      step();
    end
    for (int i = 0; i < 2; i++) ld_en[i] = 1'b0;

    // Single fetch and a back-to-back stream on the zero-wait instance
    req(0, 32'h0);
    step();
    for (int k = 0; k < 4; k++) begin
      req_valid[0] = 1'b1;
      req_pc[0]    = 32'(k * 4);
      step();
    end
    req_valid[0] = 1'b0;
    step();

    // Decode stall for five cycles with the next PC waiting
    req(0, 32'h10);
    req_valid[0] = 1'b1;
    req_pc[0]    = 32'h14;
    rsp_ready[0] = 1'b0;
    repeat (5) step();
    rsp_ready[0] = 1'b1;
    step();
    req_valid[0] = 1'b0;
    step();

    // Flush while a response is pending, with a competing request
    req(0, 32'h18);
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b1;
    req_pc[0]    = 32'h1C;
    flush[0]     = 1'b1;
    step();
    flush[0]     = 1'b0;
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    repeat (3) step();

    // Faulting PCs, then a load racing a capture of the same word
    req(0, 32'h6);
    req(0, 32'(MW * 4));
    req(0, 32'hFFFF_FFFC);
    ld_en[0]   = 1'b1;
    ld_addr[0] = 32'h2;
    ld_data[0] = 32'hCAFE_0093;
    req(0, 32'h8);
    ld_en[0] = 1'b0;
    req(0, 32'h8);
    step();

    // Wait-state instance: plain access, then flush in WAIT with a competing request
    req(1, 32'h10);
    repeat (5) step();
    req(1, 32'h14);
    step();
    req_valid[1] = 1'b1;
    req_pc[1]    = 32'h20;
    flush[1]     = 1'b1;
    step();
    flush[1]     = 1'b0;
    req_valid[1] = 1'b0;
    repeat (6) step();

    // Asynchronous reset in the middle of WAIT
    req(1, 32'h18);
    #2;
    rst = 1'b1;
    #1;
    chk("async rsp_valid", 1, 32'(rsp_valid[1]), 32'h0);
    chk("async rsp_instr", 1, rsp_instr[1], NOP);
    chk("async rsp_pc", 1, rsp_pc[1], 32'h0);
    chk("async rsp_fault", 1, 32'(rsp_fault[1]), 32'h0);
    step();
    rst = 1'b0;
    repeat (6) step();

    // Randomised traffic on both instances; fetch holds its PC until accepted
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!(req_valid[i] && !acc[i])) begin
          req_valid[i] = ($urandom_range(0, 9) < 6);
          req_pc[i]    = rand_pc();
        end
        rsp_ready[i] = ($urandom_range(0, 9) < 7);
        flush[i]     = ($urandom_range(0, 19) == 0);
      end
      ld_en[0]   = ($urandom_range(0, 4) == 0);
      ld_addr[0] = 32'($urandom_range(0, MW + 3));
      ld_data[0] = $urandom;
      step();
    end

    idle_inputs();
    repeat (8) step();
    for (int i = 0; i < 2; i++) chk("drain empty", i, 32'(sb[i].size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
